// File: rtl/t5_dwbs_pkg.sv
// Shared t5 definitions for the data-bus storage slave: FSM encodings,
// default bus width, default wait-state count and wait-counter width.
package t5_dwbs_pkg;

    localparam int T5_XLEN  = 32;
    localparam int T5_WAIT  = 1;
    localparam int T5_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } dwbs_state_e;

endpackage

// File: rtl/t5_dwbs_ram.sv
// Single-port 2^AW x XLEN storage with byte-lane write enables and a
// registered read port; writes and reads share one word index.
module t5_dwbs_ram
    import t5_dwbs_pkg::*;
#(
    parameter int XLEN = T5_XLEN,
    parameter int AW   = 10
) (
    input  logic                sys_clk,
    input  logic [AW-1:0]       idx,
    input  logic [XLEN/8-1:0]   we,
    input  logic [XLEN-1:0]     wdata,
    input  logic                re,
    output logic [XLEN-1:0]     rdata
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] mem [2**AW];

    // NOTE: storage has no reset; only the control path is reset, so the array
    // maps onto plain RAM and its contents survive a reset.
    always_ff @(posedge sys_clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we[b]) begin
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/t5_dwbs.sv
// Data-bus storage slave: captures one request, inserts WAIT wait states,
// then performs the access and returns a one-cycle ack.
module t5_dwbs
    import t5_dwbs_pkg::*;
#(
    parameter int              XLEN = T5_XLEN,
    parameter int              AW   = 10,
    parameter logic [XLEN-1:0] BASE = '0,
    parameter int              WAIT = T5_WAIT
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              sys_ena,
    input  logic [XLEN-1:2]   dwb_adr,
    input  logic [XLEN-1:0]   dwb_dto,
    input  logic [3:0]        dwb_sel,
    input  logic              dwb_stb,
    input  logic              dwb_wre,
    output logic [XLEN-1:0]   dwb_dti,
    output logic              dwb_ack
);

    localparam logic [T5_CNT_W-1:0] CNT_LOAD = (WAIT > 0) ? T5_CNT_W'(WAIT - 1) : '0;

    dwbs_state_e          state, state_nxt;
    logic [T5_CNT_W-1:0]  cnt;
    logic [XLEN-1:2]      adr_q;
    logic [XLEN-1:0]      dto_q;
    logic [3:0]           sel_q;
    logic                 wre_q;
    logic                 rd_valid;

    logic [XLEN-1:2]      req_adr;
    logic [XLEN-1:0]      req_dto;
    logic [3:0]           req_sel;
    logic                 req_wre;
    logic                 hit;
    logic                 enter_ack;
    logic [3:0]           ram_we;
    logic                 ram_re;
    logic [XLEN-1:0]      ram_rdata;

    // NOTE: every register here uses <= so all state updates see the
    // pre-edge values, regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            adr_q    <= '0;
            dto_q    <= '0;
            sel_q    <= '0;
            wre_q    <= 1'b0;
            dwb_ack  <= 1'b0;
            rd_valid <= 1'b0;
        end else if (sys_ena) begin
            state <= state_nxt;
            if (state != ST_WAIT && state_nxt == ST_WAIT) begin
                cnt <= CNT_LOAD;
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - T5_CNT_W'(1);
            end
            if (state == ST_IDLE && dwb_stb) begin
                adr_q <= dwb_adr;
                dto_q <= dwb_dto;
                sel_q <= dwb_sel;
                wre_q <= dwb_wre;
            end
            dwb_ack  <= (state_nxt == ST_ACK);
            rd_valid <= enter_ack && !req_wre && hit;
        end
    end

    // NOTE: each combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (dwb_stb) state_nxt = (WAIT > 0) ? ST_WAIT : ST_ACK;
            ST_WAIT: begin
                if (!dwb_stb) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == '0) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // With WAIT=0 the access happens on the capture edge, so IDLE uses the
    // live bus rather than the capture registers.
    always_comb begin
        req_adr = adr_q;
        req_dto = dto_q;
        req_sel = sel_q;
        req_wre = wre_q;
        if (state == ST_IDLE) begin
            req_adr = dwb_adr;
            req_dto = dwb_dto;
            req_sel = dwb_sel;
            req_wre = dwb_wre;
        end
        hit       = (req_adr[XLEN-1:AW+2] == BASE[XLEN-1:AW+2]);
        enter_ack = sys_rst && sys_ena && (state != ST_ACK) && (state_nxt == ST_ACK);
        ram_we    = (enter_ack && req_wre && hit) ? req_sel : 4'b0000;
        ram_re    = enter_ack && !req_wre;
    end

    t5_dwbs_ram #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_ram (
        .sys_clk (sys_clk),
        .idx     (req_adr[AW+1:2]),
        .we      (ram_we),
        .wdata   (req_dto),
        .re      (ram_re),
        .rdata   (ram_rdata)
    );

    // Both terms are flops, so read data is only exposed during a read ack.
    assign dwb_dti = rd_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_t5_dwbs.sv
// Directed bench for t5_dwbs: four instances cover WAIT=1, an offset BASE,
// WAIT=3 and WAIT=0, each exercised by its own scenario task.
module tb_t5_dwbs;

    localparam int ND = 4;
    localparam int TO = 40;

    logic clk;
    logic             rst [ND];
    logic             ena [ND];
    logic             stb [ND];
    logic             wre [ND];
    logic [31:2]      adr [ND];
    logic [31:0]      dto [ND];
    logic [3:0]       sel [ND];
    logic [31:0]      dti [ND];
    logic             ack [ND];

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    t5_dwbs #(.WAIT(1)) u_w1 (
        .sys_clk(clk), .sys_rst(rst[0]), .sys_ena(ena[0]), .dwb_adr(adr[0]), .dwb_dto(dto[0]),
        .dwb_sel(sel[0]), .dwb_stb(stb[0]), .dwb_wre(wre[0]), .dwb_dti(dti[0]), .dwb_ack(ack[0]));
    t5_dwbs #(.WAIT(1), .BASE(32'h0000_1000)) u_base (
        .sys_clk(clk), .sys_rst(rst[1]), .sys_ena(ena[1]), .dwb_adr(adr[1]), .dwb_dto(dto[1]),
        .dwb_sel(sel[1]), .dwb_stb(stb[1]), .dwb_wre(wre[1]), .dwb_dti(dti[1]), .dwb_ack(ack[1]));
    t5_dwbs #(.WAIT(3)) u_w3 (
        .sys_clk(clk), .sys_rst(rst[2]), .sys_ena(ena[2]), .dwb_adr(adr[2]), .dwb_dto(dto[2]),
        .dwb_sel(sel[2]), .dwb_stb(stb[2]), .dwb_wre(wre[2]), .dwb_dti(dti[2]), .dwb_ack(ack[2]));
    t5_dwbs #(.WAIT(0)) u_w0 (
        .sys_clk(clk), .sys_rst(rst[3]), .sys_ena(ena[3]), .dwb_adr(adr[3]), .dwb_dto(dto[3]),
        .dwb_sel(sel[3]), .dwb_stb(stb[3]), .dwb_wre(wre[3]), .dwb_dti(dti[3]), .dwb_ack(ack[3]));

    // One complete access on instance d; lat is the number of cycles from the
    // stb-sampling edge until ack is seen, or -1 if ack never arrives.
    task automatic access(input int d, input logic w, input logic [31:0] badr,
                          input logic [31:0] data, input logic [3:0] s,
                          output logic [31:0] rdata, output int lat);
        @(negedge clk);
        adr[d] = badr[31:2];
        dto[d] = data;
        sel[d] = s;
        wre[d] = w;
        stb[d] = 1'b1;
        lat    = -1;
        rdata  = 32'hxxxx_xxxx;
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            if (ack[d] === 1'b1) begin
                lat   = i;
                rdata = dti[d];
                break;
            end
        end
        stb[d] = 1'b0;
        wre[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b0; ena[d] = 1'b1; stb[d] = 1'b0; wre[d] = 1'b0;
            adr[d] = '0;   dto[d] = '0;   sel[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (ack[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ack[%0d]: got %b, want 0", d, ack[d]);
            end
            n_checks++;
            if (dti[d] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_dti[%0d]: got %h, want 0", d, dti[d]);
            end
        end
        for (int d = 0; d < ND; d++) rst[d] = 1'b1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int          lat;
        access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d, want 2", lat); end
        access(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d, want 2", lat); end
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h, want deadbeef", rd); end
        @(negedge clk);
        n_checks++;
        if (ack[0] !== 1'b0 || dti[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL post_ack: got ack=%b dti=%h, want ack=0 dti=0", ack[0], dti[0]);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        int          lat;
        access(0, 1'b1, 32'h10, 32'h0000_AA00, 4'h2, rd, lat);
        access(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat);
        n_checks++;
        if (rd !== 32'hDEAD_AAEF) begin n_fail++; $display("FAIL lane_merge: got %h, want deadaaef", rd); end
        access(0, 1'b1, 32'h10, 32'h1234_5678, 4'h0, rd, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL sel0_ack: got latency %0d, want 2", lat); end
        access(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat);
        n_checks++;
        if (rd !== 32'hDEAD_AAEF) begin n_fail++; $display("FAIL sel0_nochange: got %h, want deadaaef", rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        int          lat;
        access(1, 1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, rd, lat);
        access(1, 1'b0, 32'h1000, 32'h0, 4'hF, rd, lat);
        n_checks++;
        if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL base_rd: got %h, want cafef00d", rd); end
        access(1, 1'b0, 32'h0, 32'h0, 4'hF, rd, lat);
        n_checks++;
        if (lat !== 2 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_rd: got latency %0d data %h, want latency 2 data 0", lat, rd);
        end
        access(1, 1'b1, 32'h0, 32'h1111_1111, 4'hF, rd, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL oor_wr_ack: got latency %0d, want 2", lat); end
        access(1, 1'b0, 32'h1000, 32'h0, 4'hF, rd, lat);
        n_checks++;
        if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL oor_wr_dropped: got %h, want cafef00d", rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int          lat;
        int          acks;
        access(2, 1'b1, 32'h20, 32'h55AA_55AA, 4'hF, rd, lat);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL w3_latency: got %0d, want 4", lat); end
        @(negedge clk);
        adr[2] = 30'h20 >> 2; dto[2] = 32'hFFFF_FFFF; sel[2] = 4'hF; wre[2] = 1'b1; stb[2] = 1'b1;
        repeat (2) @(negedge clk);
        stb[2] = 1'b0; wre[2] = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[2] === 1'b1) acks++;
        end
        n_checks++;
        if (acks !== 0) begin n_fail++; $display("FAIL abort_noack: got %0d acks, want 0", acks); end
        access(2, 1'b0, 32'h20, 32'h0, 4'hF, rd, lat);
        n_checks++;
        if (rd !== 32'h55AA_55AA) begin n_fail++; $display("FAIL abort_nowrite: got %h, want 55aa55aa", rd); end
    endtask

    task automatic test_reset_ena();
        logic [31:0] rd;
        int          lat;
        access(2, 1'b1, 32'h24, 32'h1357_9BDF, 4'hF, rd, lat);
        @(negedge clk);
        adr[2] = 30'h24 >> 2; dto[2] = 32'hFFFF_0000; sel[2] = 4'hF; wre[2] = 1'b1; stb[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0; stb[2] = 1'b0; wre[2] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack[2] !== 1'b0 || dti[2] !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_midaccess: got ack=%b dti=%h, want 0/0", ack[2], dti[2]);
        end
        rst[2] = 1'b1;
        access(2, 1'b0, 32'h24, 32'h0, 4'hF, rd, lat);
        n_checks++;
        if (rd !== 32'h1357_9BDF) begin n_fail++; $display("FAIL rst_retain: got %h, want 13579bdf", rd); end

        @(negedge clk);
        adr[0] = 30'h10 >> 2; wre[0] = 1'b0; sel[0] = 4'hF; stb[0] = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ack[0] !== 1'b1 || dti[0] !== 32'hDEAD_AAEF) begin
            n_fail++;
            $display("FAIL ena_pre: got ack=%b dti=%h, want 1/deadaaef", ack[0], dti[0]);
        end
        ena[0] = 1'b0; stb[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (ack[0] !== 1'b1 || dti[0] !== 32'hDEAD_AAEF) begin
                n_fail++;
                $display("FAIL ena_hold[%0d]: got ack=%b dti=%h, want 1/deadaaef", i, ack[0], dti[0]);
            end
        end
        ena[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ack[0] !== 1'b0 || dti[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL ena_release: got ack=%b dti=%h, want 0/0", ack[0], dti[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int          lat;
        logic        exp_ack;
        logic [31:0] exp_dti;
        access(3, 1'b1, 32'h0, 32'hA0A0_A0A0, 4'hF, rd, lat);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL w0_latency: got %0d, want 1", lat); end
        access(3, 1'b1, 32'h4, 32'hB1B1_B1B1, 4'hF, rd, lat);
        @(negedge clk);
        adr[3] = 30'h0; wre[3] = 1'b0; sel[3] = 4'hF; stb[3] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_ack = (i % 2 == 1);
            exp_dti = !exp_ack ? 32'h0 : (((i - 1) / 2) % 2 == 0) ? 32'hA0A0_A0A0 : 32'hB1B1_B1B1;
            n_checks++;
            if (ack[3] !== exp_ack || dti[3] !== exp_dti) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got ack=%b dti=%h, want ack=%b dti=%h", i, ack[3], dti[3], exp_ack, exp_dti);
            end
            if (ack[3] === 1'b1) adr[3] = (adr[3] == 30'h0) ? 30'h1 : 30'h0;
        end
        stb[3] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_out_of_range();
        test_abort();
        test_reset_ena();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/t5_dwbs.md
T5_DWBS -- requirements
Module: t5_dwbs

Interface
REQ-001 Parameter XLEN, default 32, data bus width in bits.
REQ-002 Parameter AW, default 10, word-address bits of internal storage, giving 2^AW words.
REQ-003 Parameter BASE, default 0, byte base address of the storage window; aligned to 2^(AW+2).
REQ-004 Parameter WAIT, default 1, wait states inserted before ack; legal range 0..15.
REQ-005 sys_clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 sys_rst  in  1  reset, synchronous, active-low.
REQ-007 sys_ena  in  1  global enable; low freezes all state.
REQ-008 dwb_adr  in  XLEN-2 [XLEN-1:2]  word address from the CPU data master.
REQ-009 dwb_dto  in  XLEN  write data from the master.
REQ-010 dwb_sel  in  4  byte-lane select; bit n covers bits [8n+7:8n].
REQ-011 dwb_stb  in  1  request strobe; the master holds it until ack.
REQ-012 dwb_wre  in  1  1 = write, 0 = read; qualified by dwb_stb.
REQ-013 dwb_dti  out  XLEN  read data to the master.
REQ-014 dwb_ack  out  1  one-cycle completion pulse.

Function
REQ-015 FSM states: IDLE, WAIT, ACK; encodings come from the shared package.
REQ-016 In IDLE with sys_ena=1 and dwb_stb=1, the block shall capture adr, dto, sel and wre; it goes to WAIT if WAIT>0, else to ACK.
REQ-017 On entry to WAIT the counter loads WAIT-1; it decrements each enabled cycle, and at 0 the next state is ACK.
REQ-018 dwb_ack shall be high exactly during the ACK cycle; request-to-ack latency is WAIT+1 cycles after the stb-sampling edge.
REQ-019 ACK always returns to IDLE, so the minimum spacing between accesses is WAIT+2 cycles; stb still high in the following IDLE starts a new access.
REQ-020 A captured write shall update only the lanes set in sel, on the edge entering ACK; sel=0 is acked without a storage change.
REQ-021 For a captured read, storage is read on the edge entering ACK, and dwb_dti shall carry the full word while dwb_ack=1 and 0 otherwise.
REQ-022 In-range means adr[XLEN-1:AW+2] equals BASE[XLEN-1:AW+2]; the index is adr[AW+1:2].
REQ-023 Out-of-range reads return 0, out-of-range writes are dropped, and both are still acked.
REQ-024 If dwb_stb drops during WAIT, the access aborts: return to IDLE with no ack and no write.
REQ-025 When sys_ena=0, the FSM, counter, capture registers, storage and the dwb_ack/dwb_dti values shall hold.
REQ-026 The block shall be combinationally transparent from no input to any output; all outputs are registered.

Reset
REQ-027 When sys_rst=0 at an edge, the FSM goes to IDLE, the counter to 0 and capture registers to 0, with dwb_ack=0 and dwb_dti=0; this overrides sys_ena.
REQ-028 Reset mid-access shall cancel the access with no ack and no write; storage contents are not reset.

Structure
REQ-029 FSM state encodings, the default XLEN and the default WAIT shall live in the shared t5 definitions package.
REQ-030 Storage shall be a sub-module t5_dwbs_ram: a 2^AW x XLEN array with byte-lane write enables and a registered read port.
REQ-031 The FSM, counter, address decode and output registers shall live in t5_dwbs.

Verification
REQ-032 WAIT=1: write adr=0x10, dto=0xDEADBEEF, sel=0xF -> ack in the 2nd cycle after stb; a read of 0x10 then returns 0xDEADBEEF with ack.
REQ-033 Write sel=0x2, dto=0x0000AA00 over 0xDEADBEEF -> a read returns 0xDEADAAEF; sel=0 leaves the word unchanged and is still acked.
REQ-034 BASE=0x1000, read adr=0x0 -> ack with dti=0; a write there is acked and a readback at a mirrored in-range index is unchanged.
REQ-035 stb dropped during WAIT with WAIT=3 -> no ack and no write; a following read returns the old data.
REQ-036 sys_rst=0 during WAIT -> IDLE with ack=0 and data retained; sys_ena=0 held 4 cycles in ACK -> ack stays 1, then clears one enabled cycle later.
REQ-037 WAIT=0, back-to-back reads with stb held high -> acks exactly every 2 cycles, with dti=0 between acks.
